// File: rtl/bram_pkg.sv
// Shared definitions for the port-B BRAM arbiter: memory map, access size codes
// and the byte-lane mask helper used on both the store and load side.
package bram_pkg;

  localparam logic [31:0] IMEM_END = 32'h0000_5000;
  localparam logic [31:0] DMEM_END = 32'h0000_8000;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } size_e;

  // Byte lanes touched by an access of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
    logic [3:0] mask;
    case (size)
      SIZE_B:  mask = 4'b0001;
      SIZE_H:  mask = 4'b0011;
      SIZE_W:  mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask << off;
  endfunction

endpackage

// File: rtl/bram_lane_align.sv
// Byte-lane alignment between a right-justified requester view and the BRAM word.
// Load=0: replicate store data to every lane. Load=1: shift read data down and mask.
module bram_lane_align
  import bram_pkg::*;
#(
  parameter bit Load = 1'b0
) (
  input  logic [31:0] data_in,
  input  size_e       size,
  input  logic [1:0]  off,
  output logic [31:0] data_out,
  output logic [3:0]  lanes
);

  assign lanes = lane_mask(size, off);

  if (Load) begin : g_load
    logic [31:0] shifted;

    assign shifted = data_in >> {off, 3'b000};

    always_comb begin
      data_out = '0;
      case (size)
        SIZE_B:  data_out = {24'h0, shifted[7:0]};
        SIZE_H:  data_out = {16'h0, shifted[15:0]};
        SIZE_W:  data_out = shifted;
        default: data_out = '0;
      endcase
    end
  end else begin : g_store
    // Replication lets the write-enable mask alone pick the target lane.
    always_comb begin
      data_out = data_in;
      case (size)
        SIZE_B:  data_out = {4{data_in[7:0]}};
        SIZE_H:  data_out = {2{data_in[15:0]}};
        default: data_out = data_in;
      endcase
    end
  end

endmodule

// File: rtl/bram_portb_arbiter.sv
// Round-robin sharing of BRAM port B between the CPU load/store path (M0) and the
// debug loader (M1), with access checking and a one-stage response pipeline.
module bram_portb_arbiter #(
  parameter logic [31:0] IMEM_END     = bram_pkg::IMEM_END,
  parameter logic [31:0] DMEM_END     = bram_pkg::DMEM_END,
  parameter bit          PROTECT_IMEM = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rsp_valid,
  output logic        m0_rsp_err,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rsp_valid,
  output logic        m1_rsp_err,
  output logic [31:0] m1_rdata,

  output logic [3:0]  bram_web,
  output logic [31:0] bram_addrb,
  output logic [31:0] bram_dib,
  input  logic [31:0] bram_dob
);

  import bram_pkg::*;

  logic        rr_ptr_q;
  logic        gnt0, gnt1, any_gnt, sel;

  logic        g_we;
  size_e       g_size;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;

  logic        size_err, align_err, range_err, prot_err, acc_err;
  logic [31:0] st_data;
  logic [3:0]  st_lanes;

  logic        rsp_valid_q;
  logic        owner_q;
  logic [1:0]  off_q;
  size_e       size_q;
  logic        err_q;
  logic [31:0] ld_data;
  logic [3:0]  unused_rsp_lanes;

  // On contention the requester that was not granted last wins.
  assign gnt0    = !rst && m0_req && (!m1_req || rr_ptr_q);
  assign gnt1    = !rst && m1_req && (!m0_req || !rr_ptr_q);
  assign any_gnt = gnt0 || gnt1;
  assign sel     = gnt1;

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  assign g_we    = sel ? m1_we : m0_we;
  assign g_size  = sel ? size_e'(m1_size) : size_e'(m0_size);
  assign g_addr  = sel ? m1_addr : m0_addr;
  assign g_wdata = sel ? m1_wdata : m0_wdata;

  assign size_err  = (g_size == SIZE_X);
  assign align_err = ((g_size == SIZE_H) && g_addr[0]) ||
                     ((g_size == SIZE_W) && (g_addr[1:0] != 2'b00));
  assign range_err = (g_addr >= DMEM_END);
  assign prot_err  = PROTECT_IMEM && !sel && g_we && (g_addr < IMEM_END);
  assign acc_err   = size_err || align_err || range_err || prot_err;

  bram_lane_align #(
    .Load (1'b0)
  ) u_store_align (
    .data_in  (g_wdata),
    .size     (g_size),
    .off      (g_addr[1:0]),
    .data_out (st_data),
    .lanes    (st_lanes)
  );

  assign bram_addrb = {g_addr[31:2], 2'b00};
  assign bram_dib   = st_data;
  assign bram_web   = (any_gnt && g_we && !acc_err && !rst) ? st_lanes : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      owner_q     <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= SIZE_B;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= any_gnt;
      if (any_gnt) begin
        rr_ptr_q <= sel;
        owner_q  <= sel;
        off_q    <= g_addr[1:0];
        size_q   <= g_size;
        err_q    <= acc_err;
      end
    end
  end

  bram_lane_align #(
    .Load (1'b1)
  ) u_load_align (
    .data_in  (bram_dob),
    .size     (size_q),
    .off      (off_q),
    .data_out (ld_data),
    .lanes    (unused_rsp_lanes)
  );

  // Gating with rst drops a response that is in flight when reset arrives.
  assign m0_rsp_valid = rsp_valid_q && !owner_q && !rst;
  assign m1_rsp_valid = rsp_valid_q && owner_q && !rst;
  assign m0_rsp_err   = m0_rsp_valid && err_q;
  assign m1_rsp_err   = m1_rsp_valid && err_q;
  assign m0_rdata     = (m0_rsp_valid && !err_q) ? ld_data : 32'h0;
  assign m1_rdata     = (m1_rsp_valid && !err_q) ? ld_data : 32'h0;

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Directed bench for bram_portb_arbiter against a read-first BRAM model preloaded
// with mem[i]=i (word index).
module tb_bram_portb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        preload;

  logic        m0_req, m0_we, m0_gnt, m0_rsp_valid, m0_rsp_err;
  logic [1:0]  m0_size;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rsp_valid, m1_rsp_err;
  logic [1:0]  m1_size;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  bram_web;
  logic [31:0] bram_addrb, bram_dib, bram_dob;

  logic [31:0] mem [0:8191];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bram_portb_arbiter u_dut (
    .clk          (clk),
    .rst          (rst),
    .m0_req       (m0_req),
    .m0_we        (m0_we),
    .m0_size      (m0_size),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_gnt       (m0_gnt),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rsp_err   (m0_rsp_err),
    .m0_rdata     (m0_rdata),
    .m1_req       (m1_req),
    .m1_we        (m1_we),
    .m1_size      (m1_size),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_gnt       (m1_gnt),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rsp_err   (m1_rsp_err),
    .m1_rdata     (m1_rdata),
    .bram_web     (bram_web),
    .bram_addrb   (bram_addrb),
    .bram_dib     (bram_dib),
    .bram_dob     (bram_dob)
  );

  // Read-first BRAM port B model
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8192; i++) mem[i] <= i;
    end else begin
      bram_dob <= mem[bram_addrb[14:2]];
      for (int b = 0; b < 4; b++)
        if (bram_web[b]) mem[bram_addrb[14:2]][8*b +: 8] <= bram_dib[8*b +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int m, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic clear_req();
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  // One isolated access: grant-cycle checks, then response-cycle checks.
  task automatic access(input string tag, input int m, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] exp_web, input logic exp_err,
                        input logic chk_rdata, input logic [31:0] exp_rdata);
    @(posedge clk); #1;
    set_req(m, we, size, addr, wdata);
    @(negedge clk);
    check_eq({tag, ".gnt"}, (m == 0) ? m0_gnt : m1_gnt, 32'd1);
    check_eq({tag, ".other_gnt"}, (m == 0) ? m1_gnt : m0_gnt, 32'd0);
    check_eq({tag, ".web"}, bram_web, exp_web);
    check_eq({tag, ".addrb"}, bram_addrb, {addr[31:2], 2'b00});
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    check_eq({tag, ".rsp_valid"}, (m == 0) ? m0_rsp_valid : m1_rsp_valid, 32'd1);
    check_eq({tag, ".other_rsp"}, (m == 0) ? m1_rsp_valid : m0_rsp_valid, 32'd0);
    check_eq({tag, ".err"}, (m == 0) ? m0_rsp_err : m1_rsp_err, exp_err);
    if (chk_rdata) check_eq({tag, ".rdata"}, (m == 0) ? m0_rdata : m1_rdata, exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; preload = 1'b1;
    m0_req = 0; m0_we = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
    @(posedge clk); #1; preload = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst.m0_gnt", m0_gnt, 0);
    check_eq("rst.m1_gnt", m1_gnt, 0);
    check_eq("rst.m0_rsp_valid", m0_rsp_valid, 0);
    check_eq("rst.m1_rsp_valid", m1_rsp_valid, 0);
    check_eq("rst.m0_rsp_err", m0_rsp_err, 0);
    check_eq("rst.m0_rdata", m0_rdata, 0);
    check_eq("rst.web", bram_web, 0);
    @(posedge clk); #1; rst = 1'b0;

    // 1. plain word load
    access("t1.ld", 0, 1'b0, 2'd2, 32'h5004, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0000_1401);

    // 2. byte store from M1, then read the word back
    @(posedge clk); #1;
    set_req(1, 1'b1, 2'd0, 32'h5006, 32'h0000_00AB);
    @(negedge clk);
    check_eq("t2.st.gnt", m1_gnt, 1);
    check_eq("t2.st.web", bram_web, 4'b0100);
    check_eq("t2.st.dib", bram_dib, 32'hABAB_ABAB);
    @(posedge clk); #1; clear_req();
    @(negedge clk);
    check_eq("t2.st.rsp_valid", m1_rsp_valid, 1);
    check_eq("t2.st.err", m1_rsp_err, 0);
    access("t2.ld", 0, 1'b0, 2'd2, 32'h5004, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h00AB_1401);

    // 3. contention after reset alternates M1, M0, M1, M0
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        set_req(0, 1'b0, 2'd2, 32'h5000, 32'h0);
        set_req(1, 1'b0, 2'd2, 32'h6000, 32'h0);
      end
      if (k == 4) clear_req();
      @(negedge clk);
      if (k < 4) begin
        check_eq($sformatf("t3.c%0d.m1_gnt", k), m1_gnt, (k % 2 == 0) ? 1 : 0);
        check_eq($sformatf("t3.c%0d.m0_gnt", k), m0_gnt, (k % 2 == 1) ? 1 : 0);
      end
      if (k > 0) begin
        check_eq($sformatf("t3.c%0d.m1_rsp", k), m1_rsp_valid, ((k - 1) % 2 == 0) ? 1 : 0);
        check_eq($sformatf("t3.c%0d.m0_rsp", k), m0_rsp_valid, ((k - 1) % 2 == 1) ? 1 : 0);
        check_eq($sformatf("t3.c%0d.m1_rdata", k), m1_rdata,
                 ((k - 1) % 2 == 0) ? 32'h1800 : 32'h0);
        check_eq($sformatf("t3.c%0d.m0_rdata", k), m0_rdata,
                 ((k - 1) % 2 == 1) ? 32'h1400 : 32'h0);
      end
    end

    // 4. misaligned half, protected IMEM store, same store from M1
    access("t4.half", 0, 1'b0, 2'd1, 32'h5003, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h0);
    access("t4.prot", 0, 1'b1, 2'd2, 32'h0100, 32'hDEAD_BEEF, 4'b0000, 1'b1, 1'b1, 32'h0);
    check_eq("t4.prot.mem", mem[32'h40], 32'h0000_0040);
    access("t4.m1st", 1, 1'b1, 2'd2, 32'h0100, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, 32'h0);
    check_eq("t4.m1st.mem", mem[32'h40], 32'hDEAD_BEEF);
    access("t4.illsz", 1, 1'b0, 2'd3, 32'h5000, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h0);

    // 5. out of range, then byte/half loads from the top lanes
    access("t5.oor", 0, 1'b0, 2'd2, 32'h8000, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h0);
    access("t5.st", 1, 1'b1, 2'd0, 32'h5007, 32'h0000_0080, 4'b1000, 1'b0, 1'b0, 32'h0);
    access("t5.ldb", 0, 1'b0, 2'd0, 32'h5007, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0000_0080);
    access("t5.ldh", 0, 1'b0, 2'd1, 32'h5006, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0000_80AB);
    access("t5.sth", 0, 1'b1, 2'd1, 32'h5012, 32'h0000_BEEF, 4'b1100, 1'b0, 1'b0, 32'h0);
    check_eq("t5.sth.mem", mem[32'h1404], 32'hBEEF_1404);

    // 6. reset right after a store grant, then reset during a request
    @(posedge clk); #1;
    set_req(0, 1'b1, 2'd2, 32'h5010, 32'h1234_5678);
    @(negedge clk);
    check_eq("t6.gnt", m0_gnt, 1);
    check_eq("t6.web", bram_web, 4'b1111);
    @(posedge clk); #1; clear_req(); rst = 1'b1;
    @(negedge clk);
    check_eq("t6.rsp_dropped", m0_rsp_valid, 0);
    check_eq("t6.mem_written", mem[32'h1404], 32'h1234_5678);
    @(posedge clk); #1;
    set_req(0, 1'b1, 2'd2, 32'h5014, 32'hCAFE_F00D);
    @(negedge clk);
    check_eq("t6.rst.gnt", m0_gnt, 0);
    check_eq("t6.rst.web", bram_web, 0);
    @(posedge clk); #1; rst = 1'b0;
    set_req(1, 1'b0, 2'd2, 32'h6000, 32'h0);
    @(negedge clk);
    check_eq("t6.rr.m1_gnt", m1_gnt, 1);
    check_eq("t6.rr.m0_gnt", m0_gnt, 0);
    check_eq("t6.rst.mem", mem[32'h1405], 32'h0000_1405);
    @(posedge clk); #1; clear_req();
    @(negedge clk);
    check_eq("t6.rr.m1_rsp", m1_rsp_valid, 1);
    check_eq("t6.rr.m1_rdata", m1_rdata, 32'h0000_1800);
    check_eq("t6.rr.m0_rsp", m0_rsp_valid, 0);

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
